// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, zero flag, BEQ resolution and a single-entry EX/MEM output register.
// Optional operand forwarding is enabled by defining EX_FORWARD_EN.
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_signal,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            flush,
`ifdef EX_FORWARD_EN
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] wb_data,
`endif
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] branch_target,
    output logic            zero,
    output logic            branch_taken,
    output logic            reg_write_q,
    output logic            mem_read_q,
    output logic            mem_write_q,
    output logic [4:0]      rd_q
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] op_a, rs2_path, op_b, result;
    logic            result_zero, accept;

`ifdef EX_FORWARD_EN
    // 01 selects this stage's own registered result (EX/MEM forwarding)
    always_comb begin
        op_a = rs1_val;
        case (fwd_a_sel)
            2'b01:   op_a = alu_result;
            2'b10:   op_a = wb_data;
            default: op_a = rs1_val;
        endcase
        rs2_path = rs2_val;
        case (fwd_b_sel)
            2'b01:   rs2_path = alu_result;
            2'b10:   rs2_path = wb_data;
            default: rs2_path = rs2_val;
        endcase
    end
`else
    assign op_a     = rs1_val;
    assign rs2_path = rs2_val;
`endif

    assign op_b = alu_src ? imm : rs2_path;

    always_comb begin
        result = '0;
        case (alu_signal)
            2'b00: result = op_a + op_b;
            2'b01: result = op_a - op_b;
            2'b10: result = op_a | op_b;
            2'b11: result = op_a & op_b;
        endcase
    end

    assign result_zero = (result == '0);
    assign out_valid   = (state_q == FULL);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (state_q == FULL && out_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Flush only clears the side-effecting flags; data fields keep stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result    <= '0;
            store_data    <= '0;
            branch_target <= '0;
            zero          <= 1'b0;
            branch_taken  <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            rd_q          <= '0;
        end else if (accept) begin
            alu_result    <= result;
            store_data    <= rs2_path;
            branch_target <= pc + imm;
            zero          <= result_zero;
            branch_taken  <= branch && result_zero;
            reg_write_q   <= reg_write;
            mem_read_q    <= mem_read;
            mem_write_q   <= mem_write;
            rd_q          <= rd;
        end else if (flush) begin
            branch_taken  <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios plus randomized traffic against a behavioural model.
// Forwarding scenarios are compiled in when EX_FORWARD_EN is defined.
module tb_ex_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [1:0]      alu_signal;
    logic [XLEN-1:0] rs1_val, rs2_val, imm, pc;
    logic            alu_src;
    logic [4:0]      rd;
    logic            reg_write, mem_read, mem_write, branch, flush, out_ready;
    logic            out_valid;
    logic [XLEN-1:0] alu_result, store_data, branch_target;
    logic            zero, branch_taken, reg_write_q, mem_read_q, mem_write_q;
    logic [4:0]      rd_q;
`ifdef EX_FORWARD_EN
    logic [1:0]      fwd_a_sel, fwd_b_sel;
    logic [XLEN-1:0] wb_data;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of the EX/MEM entry
    logic            m_valid;
    logic [XLEN-1:0] m_alu, m_sd, m_tgt;
    logic            m_zero, m_taken, m_rw, m_mr, m_mw;
    logic [4:0]      m_rd;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_signal(alu_signal), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_src(alu_src), .pc(pc), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .flush(flush),
`ifdef EX_FORWARD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_data(wb_data),
`endif
        .out_ready(out_ready), .out_valid(out_valid), .alu_result(alu_result),
        .store_data(store_data), .branch_target(branch_target), .zero(zero),
        .branch_taken(branch_taken), .reg_write_q(reg_write_q), .mem_read_q(mem_read_q),
        .mem_write_q(mem_write_q), .rd_q(rd_q)
    );

    task automatic model_reset();
        m_valid = 0; m_alu = 0; m_sd = 0; m_tgt = 0; m_zero = 0; m_taken = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0;
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; out_ready = 1; alu_signal = 0; rs1_val = 0; rs2_val = 0;
        imm = 0; alu_src = 0; pc = 0; rd = 0; reg_write = 0; mem_read = 0; mem_write = 0;
        branch = 0;
`ifdef EX_FORWARD_EN
        fwd_a_sel = 0; fwd_b_sel = 0; wb_data = 0;
`endif
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] im, input logic src, input logic [XLEN-1:0] p,
                             input logic [4:0] d, input logic br, input logic rw, input logic mr,
                             input logic mw);
        in_valid = 1; alu_signal = op; rs1_val = a; rs2_val = b; imm = im; alu_src = src; pc = p;
        rd = d; branch = br; reg_write = rw; mem_read = mr; mem_write = mw;
    endtask

    // Advance one clock: the model applies the handshake rules to the inputs seen at the edge.
    task automatic step();
        logic [XLEN-1:0] a, b, opb, res;
        logic            ready;
        a = rs1_val; b = rs2_val;
`ifdef EX_FORWARD_EN
        if (fwd_a_sel == 2'd1) a = m_alu; else if (fwd_a_sel == 2'd2) a = wb_data;
        if (fwd_b_sel == 2'd1) b = m_alu; else if (fwd_b_sel == 2'd2) b = wb_data;
`endif
        opb = alu_src ? imm : b;
        case (alu_signal)
            2'd0: res = a + opb;
            2'd1: res = a - opb;
            2'd2: res = a | opb;
            default: res = a & opb;
        endcase
        ready = !m_valid || out_ready;
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
        end else if (in_valid && ready) begin
            m_valid = 1; m_alu = res; m_sd = b; m_tgt = pc + imm; m_zero = (res == 0);
            m_taken = branch && (res == 0); m_rw = reg_write; m_mr = mem_read; m_mw = mem_write;
            m_rd = rd;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        model_reset();
        #12;
        compared++;
        if ({out_valid, alu_result, store_data, branch_target, zero, branch_taken, reg_write_q,
             mem_read_q, mem_write_q, rd_q} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got valid=%0b res=%h sd=%h tgt=%h rd=%0d, want all zero",
                     out_valid, alu_result, store_data, branch_target, rd_q);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        set_instr(2'd0, 5, 7, 0, 0, 0, 5'd3, 0, 1, 0, 0);
        step();
        set_idle();
        compared++;
        if ({out_valid, alu_result, zero, rd_q, reg_write_q} !== {1'b1, 32'd12, 1'b0, 5'd3, 1'b1}) begin
            mismatched++;
            $display("FAIL add_5_7: got valid=%0b res=%0d zero=%0b rd=%0d rw=%0b want 1 12 0 3 1",
                     out_valid, alu_result, zero, rd_q, reg_write_q);
        end
    endtask

    task automatic test_beq();
        set_instr(2'd1, 9, 9, 32'h20, 0, 32'h100, 5'd0, 1, 0, 0, 0);
        step();
        set_idle();
        compared++;
        if ({out_valid, zero, branch_taken, branch_target} !== {1'b1, 1'b1, 1'b1, 32'h120}) begin
            mismatched++;
            $display("FAIL beq_equal: got valid=%0b zero=%0b taken=%0b tgt=%h want 1 1 1 00000120",
                     out_valid, zero, branch_taken, branch_target);
        end
        set_instr(2'd1, 9, 8, 32'h20, 0, 32'h100, 5'd0, 1, 0, 0, 0);
        step();
        set_idle();
        compared++;
        if ({zero, branch_taken, alu_result} !== {1'b0, 1'b0, 32'd1}) begin
            mismatched++;
            $display("FAIL beq_unequal: got zero=%0b taken=%0b res=%h want 0 0 1",
                     zero, branch_taken, alu_result);
        end
    endtask

    task automatic test_wrap_logic();
        set_instr(2'd0, 32'hFFFF_FFFF, 32'd77, 1, 1, 0, 5'd1, 0, 0, 0, 0);
        step();
        compared++;
        if ({alu_result, zero, store_data} !== {32'd0, 1'b1, 32'd77}) begin
            mismatched++;
            $display("FAIL add_wrap: got res=%h zero=%0b sd=%0d want 0 1 77", alu_result, zero, store_data);
        end
        set_instr(2'd2, 32'hF0, 32'h0F, 0, 0, 0, 5'd2, 0, 0, 0, 0);
        step();
        compared++;
        if ({alu_result, zero} !== {32'hFF, 1'b0}) begin
            mismatched++;
            $display("FAIL or_op: got res=%h zero=%0b want ff 0", alu_result, zero);
        end
        set_instr(2'd3, 32'hF0, 32'h0F, 0, 0, 0, 5'd2, 1, 0, 0, 0);
        step();
        set_idle();
        compared++;
        if ({alu_result, zero, branch_taken} !== {32'h0, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL and_op: got res=%h zero=%0b taken=%0b want 0 1 1", alu_result, zero, branch_taken);
        end
    endtask

    task automatic test_stall();
        set_instr(2'd0, 100, 1, 0, 0, 0, 5'd4, 0, 1, 0, 0);
        step();
        set_instr(2'd0, 200, 2, 0, 0, 0, 5'd5, 0, 1, 0, 0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready);
            end
            step();
            compared++;
            if ({out_valid, alu_result, rd_q} !== {1'b1, 32'd101, 5'd4}) begin
                mismatched++;
                $display("FAIL stall_hold[%0d]: got valid=%0b res=%0d rd=%0d want 1 101 4",
                         i, out_valid, alu_result, rd_q);
            end
        end
        out_ready = 1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_release_ready: got %0b want 1", in_ready);
        end
        step();
        set_idle();
        compared++;
        if ({out_valid, alu_result, rd_q} !== {1'b1, 32'd202, 5'd5}) begin
            mismatched++;
            $display("FAIL stall_release_load: got valid=%0b res=%0d rd=%0d want 1 202 5",
                     out_valid, alu_result, rd_q);
        end
    endtask

    task automatic test_flush();
        set_instr(2'd0, 1, 1, 0, 0, 0, 5'd7, 1, 1, 1, 1);
        step();
        set_instr(2'd1, 3, 3, 0, 0, 0, 5'd8, 1, 1, 1, 1);
        flush = 1;
        step();
        flush = 0;
        in_valid = 0;
        compared++;
        if ({out_valid, reg_write_q, mem_write_q, mem_read_q, branch_taken} !== 5'b0) begin
            mismatched++;
            $display("FAIL flush_clear: got valid=%0b rw=%0b mw=%0b mr=%0b taken=%0b want 0 0 0 0 0",
                     out_valid, reg_write_q, mem_write_q, mem_read_q, branch_taken);
        end
        step();
        set_idle();
        compared++;
        if ({out_valid, reg_write_q} !== 2'b0) begin
            mismatched++;
            $display("FAIL flush_discard: got valid=%0b rw=%0b want 0 0", out_valid, reg_write_q);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            set_instr(2'd0, i * 10, i, 0, 0, 0, 5'(i), 0, 1, 0, 0);
            step();
            compared++;
            if ({out_valid, alu_result, rd_q} !== {1'b1, 32'(i * 11), 5'(i)}) begin
                mismatched++;
                $display("FAIL back_to_back[%0d]: got valid=%0b res=%0d rd=%0d want 1 %0d %0d",
                         i, out_valid, alu_result, rd_q, i * 11, i);
            end
        end
        set_idle();
        step();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_empty: got valid=%0b want 0", out_valid);
        end
    endtask

`ifdef EX_FORWARD_EN
    task automatic test_forward();
        set_instr(2'd0, 3, 4, 0, 0, 0, 5'd1, 0, 1, 0, 0);
        step();
        set_instr(2'd0, 32'd999, 1, 0, 0, 0, 5'd2, 0, 1, 0, 0);
        fwd_a_sel = 2'd1;
        step();
        compared++;
        if (alu_result !== 32'd8) begin
            mismatched++;
            $display("FAIL fwd_exmem: got res=%0d want 8", alu_result);
        end
        set_instr(2'd0, 16, 32'd123, 4, 1, 0, 5'd0, 0, 0, 0, 1);
        fwd_a_sel = 2'd0; fwd_b_sel = 2'd2; wb_data = 32'h55;
        step();
        set_idle();
        compared++;
        if ({store_data, alu_result, mem_write_q} !== {32'h55, 32'd20, 1'b1}) begin
            mismatched++;
            $display("FAIL fwd_wb_store: got sd=%h res=%0d mw=%0b want 55 20 1",
                     store_data, alu_result, mem_write_q);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(3) != 0);
            flush      = ($urandom_range(7) == 0);
            alu_signal = 2'($urandom_range(3));
            rs1_val    = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
            rs2_val    = ($urandom_range(3) == 0) ? rs1_val : $urandom;
            imm        = $urandom;
            alu_src    = 1'($urandom_range(1));
            pc         = $urandom;
            rd         = 5'($urandom_range(31));
            {reg_write, mem_read, mem_write, branch} = 4'($urandom_range(15));
`ifdef EX_FORWARD_EN
            fwd_a_sel = 2'($urandom_range(3));
            fwd_b_sel = 2'($urandom_range(3));
            wb_data   = $urandom;
`endif
            #1;
            compared++;
            if (in_ready !== (!m_valid || out_ready)) begin
                mismatched++;
                $display("FAIL rand_in_ready[%0d]: got %0b want %0b", i, in_ready, !m_valid || out_ready);
            end
            step();
            compared++;
            if ({out_valid, branch_taken, reg_write_q, mem_read_q, mem_write_q} !==
                {m_valid, m_taken, m_rw, m_mr, m_mw}) begin
                mismatched++;
                $display("FAIL rand_flags[%0d]: got v=%0b t=%0b rw=%0b mr=%0b mw=%0b want %0b %0b %0b %0b %0b",
                         i, out_valid, branch_taken, reg_write_q, mem_read_q, mem_write_q,
                         m_valid, m_taken, m_rw, m_mr, m_mw);
            end
            if (m_valid) begin
                compared++;
                if ({alu_result, store_data, branch_target, zero, rd_q} !==
                    {m_alu, m_sd, m_tgt, m_zero, m_rd}) begin
                    mismatched++;
                    $display("FAIL rand_data[%0d]: got res=%h sd=%h tgt=%h z=%0b rd=%0d want %h %h %h %0b %0d",
                             i, alu_result, store_data, branch_target, zero, rd_q,
                             m_alu, m_sd, m_tgt, m_zero, m_rd);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        set_instr(2'd0, 40, 2, 0, 0, 0, 5'd9, 0, 1, 0, 1);
        step();
        out_ready = 0;
        step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        compared++;
        if ({out_valid, alu_result, rd_q, reg_write_q, mem_write_q} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_stall: got valid=%0b res=%0d rd=%0d rw=%0b mw=%0b want all 0",
                     out_valid, alu_result, rd_q, reg_write_q, mem_write_q);
        end
        set_idle();
        @(negedge clk);
        rst_n = 1;
        step();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_survivor: got valid=%0b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_beq();
        test_wrap_logic();
        test_stall();
        test_flush();
        test_back_to_back();
`ifdef EX_FORWARD_EN
        test_forward();
`endif
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
